rtc_shadow_stream: RTL and testbench
====================================

Name: rtc_shadow_stream

Overview:
Parametrised successor to the RTC register capture/serialiser between the RTC SPI controller and the VGA text renderer. Captures writes in two address windows (clock/date window and timer window) into a live register bank. On request, or continuously, it snapshots the bank and streams it one word per handshake to the VGA side with start/end-of-frame markers. It also provides per-register dirty flags and a read-strobe word counter with a wrap pulse, replacing the old negedge-driven counter.

Parameters:
DATA_W, 8, register word width
ADDR_W, 8, write address width
BASE_A, 8'h21, first address of window A (clock/date)
COUNT_A, 8, registers in window A
BASE_B, 8'h41, first address of window B (timer)
COUNT_B, 3, registers in window B
GAP_CYCLES, 1, idle cycles after a frame before the next start is allowed (0 = none)
Derived localparams: NUM_REGS = COUNT_A+COUNT_B; IDX_W = clog2(NUM_REGS), minimum 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active-low
wr_en  in  1  write strobe from the RTC controller
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
continuous  in  1  1 = restart a frame automatically after each gap
frame_req  in  1  single-cycle request for one frame
out_ready  in  1  consumer accepts the current word
out_valid  out  1  out_data/out_idx are valid
out_data  out  DATA_W  snapshot word
out_idx  out  IDX_W  bank index of out_data
out_sof  out  1  high with the word at index 0
out_eof  out  1  high with the word at index NUM_REGS-1
busy  out  1  FSM not in IDLE
dirty  out  NUM_REGS  per-register "written since last snapshot" flags
rd_strobe  in  1  word-read pulse from the SPI side
rd_count  out  IDX_W  words read in the current burst
rd_wrap  out  1  one-cycle pulse when rd_count wraps

Behaviour:
- Reset (asynchronous, reset_n=0): live bank, shadow bank, dirty, rd_count and pending cleared. FSM goes to IDLE. out_valid, out_sof, out_eof, busy and rd_wrap are 0. out_data=0 and out_idx=0. Reset mid-frame aborts the frame with no eof.
- Address decode: an address in [BASE_A, BASE_A+COUNT_A) maps to idx = addr-BASE_A. An address in [BASE_B, BASE_B+COUNT_B) maps to idx = COUNT_A+addr-BASE_B. Any other address is ignored.
- Write (wr_en with a decoded hit): live[idx] <= wr_data and dirty[idx] <= 1 on the next edge.
- pending: set by frame_req in any state, one deep. Extra requests while pending is already set are merged.
- FSM IDLE -> LOAD: when pending=1 or continuous=1.
- FSM LOAD (1 cycle):
  - shadow <= live; dirty <= 0; pending <= 0.
  - A write in the same cycle updates live and sets its dirty bit (write wins over clear). The shadow takes the pre-write value.
- FSM STREAM:
  - out_valid=1, out_data=shadow[ptr], out_idx=ptr, out_sof=(ptr==0), out_eof=(ptr==NUM_REGS-1).
  - ptr advances only when out_valid && out_ready.
  - Outputs stay stable while out_ready=0.
  - Acceptance of the last word -> GAP, or IDLE if GAP_CYCLES=0.
- FSM GAP: counts GAP_CYCLES, then -> IDLE. out_valid=0.
- Latency: frame_req at edge n -> LOAD in cycle n+1 -> first word valid in cycle n+2 (from IDLE).
- The shadow is frozen for the whole frame: writes during STREAM never alter the streamed words.
- busy=1 in LOAD, STREAM and GAP.
- Read counter:
  - rd_strobe increments rd_count on the clock edge (no derived clocks).
  - At NUM_REGS-1 the next strobe gives rd_count=0 and rd_wrap=1 for one cycle.
  - rd_count holds when there is no strobe.

Decomposition:
- Shared package: default window bases/counts (RTC_BASE_A, RTC_BASE_B), DATA_W, and an FSM state enum (IDLE, LOAD, STREAM, GAP).
- Sub-module rtc_addr_decode: combinational addr -> {hit, idx}; reused by the SPI controller.

Test Plan:
- Reset, then write 8'h21<=8'h15, 8'h28<=8'h99, 8'h43<=8'h07, then frame_req with out_ready=1 -> 11 consecutive words. idx0=8'h15 with sof, idx7=8'h99, idx10=8'h07 with eof. dirty=0 after LOAD.
- Write to 8'h20, 8'h29, 8'h40 and 8'h44 -> no live change, dirty stays 0, next frame is all zeros.
- During STREAM, hold out_ready=0 for 5 cycles at idx3 and write 8'h24<=8'hAA -> out_data/out_idx stable. The frame shows the old idx3 value. dirty[3]=1 after the frame.
- continuous=1, GAP_CYCLES=2, out_ready=1 -> frames repeat with exactly 2 idle cycles between eof and the next LOAD. A frame_req during STREAM causes no extra frame beyond one pending.
- Write 8'h22 in the same cycle as LOAD -> the shadow has the old value and dirty[1]=1 after LOAD.
- 11 rd_strobe pulses -> rd_count 1..10 then 0 with rd_wrap high for one cycle. Assert reset_n=0 mid-STREAM -> immediate out_valid=0 and rd_count=0.

Source files
------------

// File: rtl/rtc_shadow_stream_pkg.sv
// Shared definitions for the RTC register capture / shadow streaming block
// and the RTC SPI controller that reuses its address decoder.
package rtc_shadow_stream_pkg;

  localparam int         RTC_DATA_W  = 8;
  localparam int         RTC_ADDR_W  = 8;
  localparam logic [7:0] RTC_BASE_A  = 8'h21;
  localparam int         RTC_COUNT_A = 8;
  localparam logic [7:0] RTC_BASE_B  = 8'h41;
  localparam int         RTC_COUNT_B = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    GAP
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_shadow_stream_decode.sv
// Combinational write-address decoder: maps the clock/date window and the
// timer window onto one contiguous register index space.
module rtc_addr_decode
  import rtc_shadow_stream_pkg::*;
#(
  parameter int                ADDR_W  = RTC_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_A  = RTC_BASE_A,
  parameter int                COUNT_A = RTC_COUNT_A,
  parameter logic [ADDR_W-1:0] BASE_B  = RTC_BASE_B,
  parameter int                COUNT_B = RTC_COUNT_B,
  parameter int                IDX_W   = idx_width(COUNT_A + COUNT_B)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  localparam logic [ADDR_W-1:0] CNT_A = ADDR_W'(COUNT_A);
  localparam logic [ADDR_W-1:0] CNT_B = ADDR_W'(COUNT_B);
  localparam logic [IDX_W-1:0]  OFS_B = IDX_W'(COUNT_A);

  logic [ADDR_W-1:0] off_a;
  logic [ADDR_W-1:0] off_b;
  logic              hit_a;
  logic              hit_b;

  // The lower-bound test keeps a wrapped subtraction from aliasing into a window.
  always_comb begin
    off_a = addr - BASE_A;
    off_b = addr - BASE_B;
    hit_a = (addr >= BASE_A) && (off_a < CNT_A);
    hit_b = (addr >= BASE_B) && (off_b < CNT_B);
    hit   = hit_a || hit_b;
    idx   = '0;
    if (hit_a) begin
      idx = off_a[IDX_W-1:0];
    end else if (hit_b) begin
      idx = OFS_B + off_b[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/rtc_shadow_stream.sv
// Captures RTC register writes into a live bank, snapshots it on request and
// streams the frozen snapshot to the VGA side; also counts SPI word reads.
module rtc_shadow_stream
  import rtc_shadow_stream_pkg::*;
#(
  parameter int                DATA_W     = RTC_DATA_W,
  parameter int                ADDR_W     = RTC_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_A     = RTC_BASE_A,
  parameter int                COUNT_A    = RTC_COUNT_A,
  parameter logic [ADDR_W-1:0] BASE_B     = RTC_BASE_B,
  parameter int                COUNT_B    = RTC_COUNT_B,
  parameter int                GAP_CYCLES = 1,
  localparam int               NUM_REGS   = COUNT_A + COUNT_B,
  localparam int               IDX_W      = idx_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                continuous,
  input  logic                frame_req,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_sof,
  output logic                out_eof,
  output logic                busy,
  output logic [NUM_REGS-1:0] dirty,
  input  logic                rd_strobe,
  output logic [IDX_W-1:0]    rd_count,
  output logic                rd_wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam int               GAP_W    = idx_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] live   [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [IDX_W-1:0]  ptr;
  logic [GAP_W-1:0]  gap_cnt;
  logic              pending;
  logic              wr_hit;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_fire;
  logic              start;

  rtc_addr_decode #(
    .ADDR_W  (ADDR_W),
    .BASE_A  (BASE_A),
    .COUNT_A (COUNT_A),
    .BASE_B  (BASE_B),
    .COUNT_B (COUNT_B),
    .IDX_W   (IDX_W)
  ) u_decode (
    .addr (wr_addr),
    .hit  (wr_hit),
    .idx  (wr_idx)
  );

  assign wr_fire = wr_en && wr_hit;
  assign start   = pending || continuous;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) live[i] <= '0;
    end else if (wr_fire) begin
      live[wr_idx] <= wr_data;
    end
  end

  // The snapshot is taken from the registered bank, so a write landing on the
  // LOAD edge is seen by live but not by shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (state == LOAD) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= live[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty   <= '0;
      pending <= 1'b0;
    end else begin
      if (state == LOAD) dirty <= '0;
      if (wr_fire) dirty[wr_idx] <= 1'b1;
      if (frame_req) begin
        pending <= 1'b1;
      end else if (state == LOAD) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        ptr <= '0;
      end else if (state == STREAM && out_ready && ptr != LAST_IDX) begin
        ptr <= ptr + 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Leaving GAP (or the last word when there is no gap) goes straight to LOAD
  // if a frame is wanted, so exactly GAP_CYCLES idle cycles separate frames.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = shadow[ptr];
        out_idx   = ptr;
        out_sof   = (ptr == '0);
        out_eof   = (ptr == LAST_IDX);
        if (out_ready && ptr == LAST_IDX) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
          end else begin
            state_nxt = start ? LOAD : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = start ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
      rd_wrap  <= 1'b0;
    end else begin
      rd_wrap <= 1'b0;
      if (rd_strobe) begin
        if (rd_count == LAST_IDX) begin
          rd_count <= '0;
          rd_wrap  <= 1'b1;
        end else begin
          rd_count <= rd_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_shadow_stream.sv
// Directed bench for rtc_shadow_stream: expected frame words go into a
// scoreboard queue that a negedge monitor drains on every accepted word.
module tb_rtc_shadow_stream;

  localparam int NREG = 11;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
    logic       sof;
    logic       eof;
  } exp_t;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic        wr_en      = 1'b0;
  logic [7:0]  wr_addr    = '0;
  logic [7:0]  wr_data    = '0;
  logic        continuous = 1'b0;
  logic        frame_req  = 1'b0;
  logic        out_ready  = 1'b0;
  logic        rd_strobe  = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_idx;
  logic        out_sof;
  logic        out_eof;
  logic        busy;
  logic [10:0] dirty;
  logic [3:0]  rd_count;
  logic        rd_wrap;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] model_live [NREG];
  int         n_checks = 0;
  int         n_fail   = 0;

  rtc_shadow_stream #(.GAP_CYCLES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .continuous (continuous),
    .frame_req  (frame_req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .busy       (busy),
    .dirty      (dirty),
    .rd_strobe  (rd_strobe),
    .rd_count   (rd_count),
    .rd_wrap    (rd_wrap)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every word accepted by the consumer must match the queue head.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_word", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_output("word_data", out_data, mon_e.data);
        check_output("word_idx",  out_idx,  mon_e.idx);
        check_output("word_sof",  out_sof,  mon_e.sof);
        check_output("word_eof",  out_eof,  mon_e.eof);
      end
    end
  end

  function automatic int model_idx(input logic [7:0] a);
    if (a >= 8'h21 && a <= 8'h28) return int'(a - 8'h21);
    if (a >= 8'h41 && a <= 8'h43) return 8 + int'(a - 8'h41);
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] addr, input logic [7:0] data);
    int k;
    wr_addr = addr;
    wr_data = data;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    k = model_idx(addr);
    if (k >= 0) model_live[k] = data;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NREG; i++)
      sb_q.push_back({model_live[i], 4'(i), (i == 0), (i == NREG - 1)});
  endtask

  task automatic issue_frame(input bit check_lat);
    push_frame();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    if (check_lat) begin
      check_output("lat_req_cycle_busy", busy, 1'b0);
      tick();
      check_output("lat_load_busy", busy, 1'b1);
      check_output("lat_load_valid", out_valid, 1'b0);
      tick();
      check_output("lat_first_valid", out_valid, 1'b1);
      check_output("dirty_after_load", dirty, 11'h000);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    check_output("frame_done_timeout", (n >= 300), 1'b0);
    check_output("sb_drained", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    wr_en      = 1'b0;
    frame_req  = 1'b0;
    continuous = 1'b0;
    rd_strobe  = 1'b0;
    #1;
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_data", out_data, 8'h00);
    check_output("rst_out_idx", out_idx, 4'h0);
    check_output("rst_sof_eof", {out_sof, out_eof}, 2'b00);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_dirty", dirty, 11'h000);
    check_output("rst_rd_count", rd_count, 4'h0);
    check_output("rst_rd_wrap", rd_wrap, 1'b0);
    sb_q.delete();
    for (int i = 0; i < NREG; i++) model_live[i] = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check_output("post_reset_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int idle;
    bit drop;
    bit saw_valid;

    #2;
    do_reset();

    // Basic capture and a full frame
    out_ready = 1'b1;
    apply_stimulus(8'h21, 8'h15);
    apply_stimulus(8'h28, 8'h99);
    apply_stimulus(8'h43, 8'h07);
    check_output("dirty_after_writes", dirty, 11'h481);
    issue_frame(1);
    check_output("first_word_sof", out_sof, 1'b1);
    wait_idle();

    // Addresses just outside both windows are ignored
    do_reset();
    out_ready = 1'b1;
    apply_stimulus(8'h20, 8'hFF);
    apply_stimulus(8'h29, 8'hFF);
    apply_stimulus(8'h40, 8'hFF);
    apply_stimulus(8'h44, 8'hFF);
    check_output("dirty_outside_windows", dirty, 11'h000);
    issue_frame(1);
    wait_idle();

    // Back-pressure at idx3 with a write to idx3 during the stall
    out_ready = 1'b0;
    apply_stimulus(8'h24, 8'h33);
    issue_frame(1);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output("stall_valid", out_valid, 1'b1);
      check_output("stall_idx", out_idx, 4'd3);
      check_output("stall_data", out_data, 8'h33);
      if (i == 0) apply_stimulus(8'h24, 8'hAA);
      else tick();
    end
    out_ready = 1'b1;
    wait_idle();
    check_output("dirty_after_stall", dirty, 11'h008);

    // Write landing in the LOAD cycle
    apply_stimulus(8'h22, 8'h11);
    issue_frame(0);
    tick();
    check_output("coll_load_busy", busy, 1'b1);
    check_output("coll_load_valid", out_valid, 1'b0);
    apply_stimulus(8'h22, 8'h5C);
    check_output("coll_dirty", dirty, 11'h002);
    wait_idle();
    issue_frame(0);
    wait_idle();
    check_output("dirty_after_clean_frame", dirty, 11'h000);

    // Continuous mode: three frames, extra request merged, gap of two cycles
    push_frame();
    push_frame();
    push_frame();
    continuous = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      check_output("cont_start_timeout", (n >= 20), 1'b0);
      if (f == 0) begin
        repeat (3) tick();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
      end
      if (f == 2) continuous = 1'b0;
      n = 0;
      while (!(out_valid && out_eof) && n < 40) begin tick(); n++; end
      check_output("cont_eof_timeout", (n >= 40), 1'b0);
      tick();
      if (f < 2) begin
        idle = 0;
        drop = 1'b0;
        while (!out_valid && idle < 20) begin
          if (!busy) drop = 1'b1;
          idle++;
          tick();
        end
        check_output("cont_gap_plus_load", idle, 3);
        check_output("cont_busy_drop", drop, 1'b0);
      end
    end
    wait_idle();
    saw_valid = 1'b0;
    repeat (10) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    check_output("cont_no_extra_frame", saw_valid, 1'b0);

    // Read counter wraps after NUM_REGS strobes
    rd_strobe = 1'b1;
    for (int i = 1; i <= NREG; i++) begin
      tick();
      check_output("rd_count_step", rd_count, i % NREG);
      check_output("rd_wrap_step", rd_wrap, (i == NREG));
    end
    rd_strobe = 1'b0;
    tick();
    check_output("rd_wrap_one_cycle", rd_wrap, 1'b0);
    check_output("rd_count_after_wrap", rd_count, 4'd0);
    rd_strobe = 1'b1;
    repeat (4) tick();
    rd_strobe = 1'b0;
    repeat (3) tick();
    check_output("rd_hold", rd_count, 4'd4);

    // Reset in the middle of a stalled frame, with a request pending
    out_ready = 1'b0;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check_output("abort_stream_valid", out_valid, 1'b1);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
